// File: rtl/mem_master_pkg.sv
// rtl/mem_master_pkg.sv - shared state encoding and sizing constants for mem_master
package mem_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_TAIL = 2'd3
  } state_t;

  localparam int DEF_AW    = 8;
  localparam int DEF_DW    = 8;
  localparam int MAX_BEATS = 4;
  localparam int BEAT_W    = $clog2(MAX_BEATS);

endpackage

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-request initiator for a synchronous single-port memory
// Define MEM_MASTER_BURST_EN for 1..4 beat auto-incrementing read bursts.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          wr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_write,
  input  logic [DW-1:0] mem_q
);

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic          wr_done_q, wr_done_d;

`ifdef MEM_MASTER_BURST_EN
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] len_q, len_d;
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
`ifdef MEM_MASTER_BURST_EN
      beat_q      <= '0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
`ifdef MEM_MASTER_BURST_EN
      beat_q      <= beat_d;
      len_q       <= len_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    wr_done_d   = 1'b0;
`ifdef MEM_MASTER_BURST_EN
    beat_d      = beat_q;
    len_d       = len_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr_d  = req_addr;
          mem_data_d  = req_wdata;
          mem_write_d = req_write;
          state_d     = req_write ? WR : RD;
`ifdef MEM_MASTER_BURST_EN
          beat_d      = '0;
          len_d       = req_len;
`endif
        end
      end
      WR: begin
        wr_done_d = 1'b1;
        state_d   = IDLE;
      end
      RD: begin
`ifdef MEM_MASTER_BURST_EN
        // mem_q carries the beat issued one cycle earlier, so nothing to take on beat 0
        if (beat_q != '0) begin
          rsp_data_d  = mem_q;
          rsp_valid_d = 1'b1;
        end
        if (beat_q == len_q) begin
          state_d = RD_TAIL;
        end else begin
          beat_d     = beat_q + BEAT_W'(1);
          mem_addr_d = mem_addr_q + AW'(1);
        end
`else
        state_d = RD_TAIL;
`endif
      end
      RD_TAIL: begin
        rsp_data_d  = mem_q;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_write = mem_write_q;

endmodule
